lap_memory: RTL and testbench
=============================

# lap_memory

Word-addressed lap-time store on the chronometer control block's memory port. Accepts single-cycle writes, serves reads through a fixed-latency `rd_en`/`rd_done` handshake and tracks per-entry validity. Reports occupancy so the display path can tell how many laps are stored.

## Interface
- `ADDR_SIZE`, 4: address width; depth = 2^ADDR_SIZE words.
- `DATA_SIZE`, 16: word width.
- `RD_LATENCY`, 2: cycles from read accept to `rd_done`; legal range 1..8.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cs`  in  1  chip select; gates `wr_en` and `rd_en`.
- `wr_en`  in  1  write strobe, sampled with `cs`.
- `wr_addr`  in  ADDR_SIZE  write address.
- `wr_data`  in  DATA_SIZE  write data.
- `rd_en`  in  1  read request, sampled with `cs`.
- `rd_addr`  in  ADDR_SIZE  read address, captured at accept.
- `clear`  in  1  synchronous invalidate-all.
- `rd_data`  out  DATA_SIZE  read result; held until the next read completes.
- `rd_done`  out  1  one-cycle pulse, `rd_data` valid.
- `busy`  out  1  read in flight.
- `count`  out  ADDR_SIZE+1  number of valid entries.

## Operation
- Reset (`rst`=0, asynchronous): `rd_data`=0, `rd_done`=0, `busy`=0, `count`=0. All valid bits cleared and FSM forced to IDLE, including mid-read. Array contents are not reset.
- Write: `cs`&`wr_en` at an edge stores `wr_data` at `wr_addr` and sets its valid bit. Without `cs`, nothing happens.
- Read FSM, states IDLE, WAIT, DONE:
  - IDLE: on `cs`&`rd_en`, capture `rd_addr` and array word/valid bit (read-before-write), then go to WAIT, or to DONE if RD_LATENCY=1.
  - WAIT: a latency counter counts RD_LATENCY-1 edges, then the FSM goes to DONE.
  - DONE: `rd_done`=1 for one cycle. `rd_data` = captured word if its entry was valid, else 0. A new `cs`&`rd_en` in DONE is accepted (back-to-back), otherwise the FSM returns to IDLE.
- `rd_en` while in WAIT is ignored and not queued.
- Simultaneous read and write to the same address: the read returns the old word and old valid state.
- `clear`: all valid bits go to 0 at the edge. It beats a simultaneous write's valid set: data is written but the entry stays invalid. `count` becomes 0. A read in flight completes with the value captured at accept.
- `count` = popcount of valid bits, registered. It updates on the edge after the valid change and never wraps: max value 2^ADDR_SIZE is representable. Rewriting a valid entry leaves `count` unchanged.

## Timing
- Accept at edge E0. `busy`=1 after E0.
- `rd_done`=1 and new `rd_data` visible after edge E0+RD_LATENCY-1, for exactly one cycle. `busy`=0 in that cycle.
- Read throughput: one read every RD_LATENCY cycles maximum.
- Write latency: the word is readable by a read accepted at the edge after the write edge.
- `count` lags the valid bits by one edge.
- No combinational path from inputs to outputs.

## Structure
- Shared package `chrono_pkg`: FSM state encoding (IDLE/WAIT/DONE) and the RD_LATENCY legal-range constants, shared with the control block.
- One sub-module, `lap_mem_array`: 2^ADDR_SIZE×DATA_SIZE register array with a synchronous write port and an asynchronous read port. Valid bits, FSM, latency counter and popcount stay in `lap_memory`.

## Test plan
- Reset then read addr 3 (RD_LATENCY=2):
  - `rd_done` pulses 2 cycles after accept.
  - `rd_data`=0, `count`=0.
- Write 0x1234@5, read @5:
  - returns 0x1234, `count`=1.
  - Rewriting @5 with 0xBEEF keeps `count`=1 and a read returns 0xBEEF.
- Same-edge write 0xAAAA@2 and read @2 (held 0x5555):
  - the read returns 0x5555.
  - The next read returns 0xAAAA.
- Fill all 16 addresses:
  - `count`=16.
  - `clear` together with a write @0: `count`=0 and a read @0 returns 0.
- Back-to-back reads, `rd_en` held high:
  - `rd_done` every 2 cycles.
  - `rd_en` pulses in WAIT are ignored.
  - With `cs`=0 no accept occurs.
- Assert `rst` during WAIT:
  - outputs 0 immediately.
  - After release, a fresh read completes normally with RD_LATENCY=1 and RD_LATENCY=8 builds.

Source files
------------

// File: rtl/chrono_pkg.sv
// Shared chronometer definitions: read FSM encoding and read-latency limits.
// Imported by lap_memory and by the chronometer control block.
package chrono_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } rd_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 8;

  // Pin an out-of-range latency build to the nearest supported value.
  function automatic int clamp_lat(input int lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/lap_mem_array.sv
// Lap-time register array: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module lap_mem_array #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [DATA_SIZE-1:0] rd_word
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [DATA_SIZE-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Reads see the pre-edge word, so a same-edge write is not forwarded.
  assign rd_word = mem_q[rd_addr];

endmodule

// File: rtl/lap_memory.sv
// Lap-time store: single-cycle writes, fixed-latency reads, per-entry valid
// bits and a registered occupancy count.
//
// state   | meaning
// RD_IDLE | no read in flight, accepting cs&rd_en
// RD_WAIT | read captured, latency counter running
// RD_DONE | rd_done pulse; may accept the next read
module lap_memory
  import chrono_pkg::*;
#(
  parameter int ADDR_SIZE  = 4,
  parameter int DATA_SIZE  = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cs,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  input  logic                 clear,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 rd_done,
  output logic                 busy,
  output logic [ADDR_SIZE:0]   count
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam int CW    = ADDR_SIZE + 1;
  localparam int LAT   = clamp_lat(RD_LATENCY);
  // WAIT lasts LAT-1 cycles: load LAT-2, leave on terminal count zero.
  localparam logic [3:0] LAT_LOAD = 4'((LAT > 1) ? LAT - 2 : 0);

  rd_state_e            state_q, state_d;
  logic [3:0]           lat_cnt_q, lat_cnt_d;
  logic [DATA_SIZE-1:0] cap_word_q, cap_word_d;
  logic                 cap_valid_q, cap_valid_d;
  logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;
  logic                 rd_done_q, rd_done_d;
  logic                 busy_q, busy_d;
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [CW-1:0]        count_q, count_d;

  logic [DATA_SIZE-1:0] arr_word;
  logic                 wr_fire;
  logic                 rd_fire;

  assign wr_fire = cs & wr_en;
  assign rd_fire = cs & rd_en;

  lap_mem_array #(
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_SIZE (DATA_SIZE)
  ) u_array (
    .clk     (clk),
    .we      (wr_fire),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_word (arr_word)
  );

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    cap_word_d  = cap_word_q;
    cap_valid_d = cap_valid_q;
    rd_data_d   = rd_data_q;
    case (state_q)
      RD_IDLE, RD_DONE: begin
        if (rd_fire) begin
          if (LAT == 1) begin
            state_d   = RD_DONE;
            rd_data_d = valid_q[rd_addr] ? arr_word : '0;
          end else begin
            state_d     = RD_WAIT;
            lat_cnt_d   = LAT_LOAD;
            cap_word_d  = arr_word;
            cap_valid_d = valid_q[rd_addr];
          end
        end else begin
          state_d = RD_IDLE;
        end
      end
      RD_WAIT: begin
        if (lat_cnt_q == 4'd0) begin
          state_d   = RD_DONE;
          rd_data_d = cap_valid_q ? cap_word_q : '0;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      default: state_d = RD_IDLE;
    endcase
    rd_done_d = (state_d == RD_DONE);
    busy_d    = (state_d == RD_WAIT);
  end

  // clear wins over a same-edge write's valid set; the data still lands.
  always_comb begin
    valid_d = valid_q;
    if (clear) valid_d = '0;
    else if (wr_fire) valid_d[wr_addr] = 1'b1;
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) count_d = count_d + CW'(valid_q[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RD_IDLE;
      lat_cnt_q   <= '0;
      cap_word_q  <= '0;
      cap_valid_q <= 1'b0;
      rd_data_q   <= '0;
      rd_done_q   <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      cap_word_q  <= cap_word_d;
      cap_valid_q <= cap_valid_d;
      rd_data_q   <= rd_data_d;
      rd_done_q   <= rd_done_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_done = rd_done_q;
  assign busy    = busy_q;
  assign count   = count_q;

endmodule

// File: tb/tb_lap_memory.sv
// Directed bench for lap_memory: RD_LATENCY=2 main instance plus 1 and 8
// builds sharing the same stimulus.
module tb_lap_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic        clear = 1'b0;

  logic [15:0] rd_data2, rd_data_l1, rd_data_l8;
  logic        rd_done2, rd_done_l1, rd_done_l8;
  logic        busy2, busy_l1, busy_l8;
  logic [4:0]  count2, count_l1, count_l8;

  int n_vec = 0;
  int n_err = 0;

  int          lat2, lat1, lat8;
  logic [15:0] dat2, dat1, dat8;
  logic        busy_k0, busy_at_done;
  logic [7:0]  done_pat, busy_pat;

  always #5 clk = ~clk;

  lap_memory #(.ADDR_SIZE(4), .DATA_SIZE(16), .RD_LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .cs(cs), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .clear(clear),
    .rd_data(rd_data2), .rd_done(rd_done2), .busy(busy2), .count(count2)
  );

  lap_memory #(.ADDR_SIZE(4), .DATA_SIZE(16), .RD_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .cs(cs), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .clear(clear),
    .rd_data(rd_data_l1), .rd_done(rd_done_l1), .busy(busy_l1), .count(count_l1)
  );

  lap_memory #(.ADDR_SIZE(4), .DATA_SIZE(16), .RD_LATENCY(8)) u_dut_l8 (
    .clk(clk), .rst(rst), .cs(cs), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .clear(clear),
    .rd_data(rd_data_l8), .rd_done(rd_done_l8), .busy(busy_l8), .count(count_l8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d);
    cs = 1'b1; wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Accept a read (plus any write already staged), then record per-build
  // latency in edges after the accept edge and the returned word.
  task automatic read_all(input logic [3:0] a);
    cs = 1'b1; rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    lat2 = -1; lat1 = -1; lat8 = -1;
    for (int k = 0; k < 16; k++) begin
      if (k == 0) busy_k0 = busy2;
      if (rd_done2 && lat2 < 0) begin lat2 = k; dat2 = rd_data2; busy_at_done = busy2; end
      if (rd_done_l1 && lat1 < 0) begin lat1 = k; dat1 = rd_data_l1; end
      if (rd_done_l8 && lat8 < 0) begin lat8 = k; dat8 = rd_data_l8; end
      if (lat2 >= 0 && lat1 >= 0 && lat8 >= 0) break;
      tick();
    end
  endtask

  task automatic run_pat(input logic [7:0] en_pat, input logic cs_v);
    for (int k = 0; k < 8; k++) begin
      cs = cs_v; rd_en = en_pat[k];
      tick();
      done_pat[k] = rd_done2;
      busy_pat[k] = busy2;
    end
    rd_en = 1'b0; cs = 1'b1;
    tick(); tick();
  endtask

  initial begin
    tick(); tick();
    chk("rst_rd_data", 32'(rd_data2), 32'h0);
    chk("rst_rd_done", 32'(rd_done2), 32'h0);
    chk("rst_busy", 32'(busy2), 32'h0);
    chk("rst_count", 32'(count2), 32'h0);
    rst = 1'b1;
    tick();

    read_all(4'd3);
    chk("empty_busy_after_accept", 32'(busy_k0), 32'h1);
    chk("empty_latency", 32'(lat2), 32'd1);
    chk("empty_busy_at_done", 32'(busy_at_done), 32'h0);
    chk("empty_data", 32'(dat2), 32'h0);
    chk("empty_count", 32'(count2), 32'h0);

    do_write(4'd5, 16'h1234);
    read_all(4'd5);
    chk("wr5_data", 32'(dat2), 32'h1234);
    chk("wr5_count", 32'(count2), 32'd1);
    do_write(4'd5, 16'hBEEF);
    read_all(4'd5);
    chk("rewr5_data", 32'(dat2), 32'hBEEF);
    chk("rewr5_count", 32'(count2), 32'd1);

    do_write(4'd2, 16'h5555);
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hAAAA;
    read_all(4'd2);
    chk("rbw_old_word", 32'(dat2), 32'h5555);
    read_all(4'd2);
    chk("rbw_new_word", 32'(dat2), 32'hAAAA);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h7777;
    read_all(4'd7);
    chk("rbw_old_invalid", 32'(dat2), 32'h0);
    read_all(4'd7);
    chk("rbw_new_valid", 32'(dat2), 32'h7777);
    chk("three_count", 32'(count2), 32'd3);

    for (int i = 0; i < 16; i++) do_write(4'(i), 16'h1000 + 16'(i));
    tick();
    chk("full_count", 32'(count2), 32'd16);
    read_all(4'd15);
    chk("full_read15", 32'(dat2), 32'h100F);

    cs = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hDDDD; clear = 1'b1;
    tick();
    wr_en = 1'b0; clear = 1'b0;
    tick();
    chk("clear_count", 32'(count2), 32'd0);
    read_all(4'd0);
    chk("clear_wr0_invalid", 32'(dat2), 32'h0);
    read_all(4'd9);
    chk("clear_rd9_invalid", 32'(dat2), 32'h0);

    do_write(4'd1, 16'h0101);
    cs = 1'b1; rd_en = 1'b1; rd_addr = 4'd1;
    tick();
    rd_en = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("inflight_clear_done", 32'(rd_done2), 32'h1);
    chk("inflight_clear_data", 32'(rd_data2), 32'h0101);
    tick();
    chk("inflight_clear_count", 32'(count2), 32'd0);

    run_pat(8'hFF, 1'b1);
    chk("b2b_done_pat", 32'(done_pat), 32'hAA);
    chk("b2b_busy_pat", 32'(busy_pat), 32'h55);
    run_pat(8'b0000_0011, 1'b1);
    chk("wait_pulse_done_pat", 32'(done_pat), 32'h02);
    chk("wait_pulse_busy_pat", 32'(busy_pat), 32'h01);
    run_pat(8'hFF, 1'b0);
    chk("nocs_done_pat", 32'(done_pat), 32'h00);
    chk("nocs_busy_pat", 32'(busy_pat), 32'h00);

    do_write(4'd6, 16'h6666);
    cs = 1'b1; rd_en = 1'b1; rd_addr = 4'd6;
    tick();
    rd_en = 1'b0;
    tick(); tick();
    chk("pre_rst_l8_busy", 32'(busy_l8), 32'h1);
    chk("pre_rst_data", 32'(rd_data2), 32'h6666);
    rst = 1'b0;
    #2;
    chk("async_rst_data", 32'(rd_data2), 32'h0);
    chk("async_rst_count", 32'(count2), 32'h0);
    chk("async_rst_l8_busy", 32'(busy_l8), 32'h0);
    chk("async_rst_l8_done", 32'(rd_done_l8), 32'h0);
    chk("async_rst_l8_data", 32'(rd_data_l8), 32'h0);
    chk("async_rst_l8_count", 32'(count_l8), 32'h0);
    chk("async_rst_l1_outs", {rd_data_l1, 10'd0, count_l1, rd_done_l1}, 32'h0);
    chk("async_rst_l1_busy", 32'(busy_l1), 32'h0);
    tick();
    rst = 1'b1;
    tick();

    do_write(4'd4, 16'h0C0C);
    read_all(4'd4);
    chk("post_rst_lat2", 32'(lat2), 32'd1);
    chk("post_rst_data2", 32'(dat2), 32'h0C0C);
    chk("post_rst_lat1", 32'(lat1), 32'd0);
    chk("post_rst_data1", 32'(dat1), 32'h0C0C);
    chk("post_rst_lat8", 32'(lat8), 32'd7);
    chk("post_rst_data8", 32'(dat8), 32'h0C0C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
